// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: state encoding and
// default parameter values.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_IF_BUSY  = 3'd1,
      ST_MEM_BUSY = 3'd2,
      ST_IF_DONE  = 3'd3,
      ST_MEM_DONE = 3'd4,
      ST_ERR      = 3'd7
   } arb_state_e;

   localparam int unsigned ADDR_W_DEF  = 32;
   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arb_wdog.sv
// Wait-cycle watchdog for the memory port arbiter: counts busy cycles without
// port_ready and flags the cycle in which the count reaches TIMEOUT.
module mem_arb_wdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Saturates at TIMEOUT so the count never wraps back into range.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // The increment happening this cycle is the one that reaches TIMEOUT.
   assign expired = en && (cnt == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between IF fetches and MEM
// loads/stores. Optional stall counters: define MEM_PORT_ARB_PERF_EN.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | no transaction; MEM request wins over IF request
// ST_IF_BUSY  | fetch presented on the port, waiting for port_ready
// ST_MEM_BUSY | load/store presented on the port, waiting for port_ready
// ST_IF_DONE  | fetch served cycle (if_rdata valid), one cycle only
// ST_MEM_DONE | load/store served cycle (mem_rdata valid), one cycle only
// ST_ERR      | watchdog expired; pipeline frozen until reset
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_stall,
   output logic              port_valid,
   output logic              port_we,
   output logic [ADDR_W-1:0] port_addr,
   output logic [DATA_W-1:0] port_wdata,
   input  logic              port_ready,
   input  logic [DATA_W-1:0] port_rdata,
   output logic              timeout_err
`ifdef MEM_PORT_ARB_PERF_EN
   ,
   output logic [31:0]       perf_if_wait,
   output logic [31:0]       perf_mem_wait
`endif
);

   arb_state_e state;
   logic       mem_req;
   logic       busy;
   logic       wd_expired;

   assign mem_req = mem_rd | mem_wr;
   assign busy    = (state == ST_IF_BUSY) || (state == ST_MEM_BUSY);

   // Every BUSY entry comes from IDLE, so clearing there restarts each wait.
   mem_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (state == ST_IDLE),
      .en      (busy && !port_ready),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         port_valid  <= 1'b0;
         port_we     <= 1'b0;
         port_addr   <= '0;
         port_wdata  <= '0;
         if_rdata    <= '0;
         mem_rdata   <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_req) begin
                  state      <= ST_MEM_BUSY;
                  port_valid <= 1'b1;
                  port_we    <= mem_wr;
                  port_addr  <= mem_addr;
                  port_wdata <= mem_wdata;
               end else if (if_req) begin
                  state      <= ST_IF_BUSY;
                  port_valid <= 1'b1;
                  port_we    <= 1'b0;
                  port_addr  <= if_addr;
               end
            end
            ST_IF_BUSY: begin
               if (port_ready) begin
                  state      <= ST_IF_DONE;
                  port_valid <= 1'b0;
                  if_rdata   <= port_rdata;
               end else if (wd_expired) begin
                  state       <= ST_ERR;
                  port_valid  <= 1'b0;
                  timeout_err <= 1'b1;
               end
            end
            ST_MEM_BUSY: begin
               if (port_ready) begin
                  state      <= ST_MEM_DONE;
                  port_valid <= 1'b0;
                  mem_rdata  <= port_rdata;
               end else if (wd_expired) begin
                  state       <= ST_ERR;
                  port_valid  <= 1'b0;
                  timeout_err <= 1'b1;
               end
            end
            ST_IF_DONE,
            ST_MEM_DONE: begin
               state <= ST_IDLE;
            end
            ST_ERR: begin
               port_valid  <= 1'b0;
               timeout_err <= 1'b1;
            end
            default: begin
               state      <= ST_IDLE;
               port_valid <= 1'b0;
            end
         endcase
      end
   end

   assign mem_stall = (state == ST_ERR) || (mem_req && (state != ST_MEM_DONE));
   assign if_stall  = (state == ST_ERR) || (if_req && (state != ST_IF_DONE)) || mem_stall;

`ifdef MEM_PORT_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_if_wait  <= '0;
         perf_mem_wait <= '0;
      end else begin
         if (if_stall && (perf_if_wait != 32'hFFFF_FFFF)) begin
            perf_if_wait <= perf_if_wait + 32'd1;
         end
         if (mem_stall && (perf_mem_wait != 32'hFFFF_FFFF)) begin
            perf_mem_wait <= perf_mem_wait + 32'd1;
         end
      end
   end
`endif

endmodule
